// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared debounce state encoding, channel indices and defaults
package input_conditioner_pkg;
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;
  localparam int NUM_CH = 3;
  localparam int SENSOR = 0;
  localparam int WALK = 1;
  localparam int PROG = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw board inputs in, conditioned controller signals out
interface input_conditioner_if;
  logic sensor_raw;
  logic walk_raw;
  logic prog_raw;
  logic sensor_sync;
  logic wr_sync;
  logic prog_sync;
  modport master (
    output sensor_raw, walk_raw, prog_raw,
    input  sensor_sync, wr_sync, prog_sync
  );
  modport slave (
    input  sensor_raw, walk_raw, prog_raw,
    output sensor_sync, wr_sync, prog_sync
  );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// input_conditioner_debounce_channel: synchroniser, debounce FSM and press strobe for one input
module input_conditioner_debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = 19,
  parameter bit PULSE = 1'b0
) (
  input  logic clock,
  input  logic reset_sync,
  input  logic i_raw,
  output logic o_out
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0] r_cnt;
  db_state_t r_state;
  logic r_level;
  logic r_rise;
  logic w_s;
  logic w_done;
  assign w_s = r_sync[SYNC_STAGES-1];
  assign w_done = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign o_out = PULSE ? r_rise : r_level;
  // metastability chain into the clock domain
  always_ff @(posedge clock or posedge reset_sync)
    if (reset_sync) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  // debounce FSM: a change is accepted only after DEBOUNCE_CYCLES equal samples; rise strobes on entry from the low side
  always_ff @(posedge clock or posedge reset_sync)
    if (reset_sync) begin
      r_state <= STABLE_LO;
      r_cnt <= '0;
      r_level <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      case (r_state)
        STABLE_LO:
          if (w_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= STABLE_HI;
              r_level <= 1'b1;
              r_rise <= 1'b1;
            end else begin
              r_state <= PEND_HI;
              r_cnt <= CNT_W'(1);
            end
          end
        PEND_HI:
          if (!w_s) begin
            r_state <= STABLE_LO;
            r_cnt <= '0;
          end else if (w_done) begin
            r_state <= STABLE_HI;
            r_cnt <= '0;
            r_level <= 1'b1;
            r_rise <= 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        STABLE_HI:
          if (!w_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= STABLE_LO;
              r_level <= 1'b0;
            end else begin
              r_state <= PEND_LO;
              r_cnt <= CNT_W'(1);
            end
          end
        PEND_LO:
          if (w_s) begin
            r_state <= STABLE_HI;
            r_cnt <= '0;
          end else if (w_done) begin
            r_state <= STABLE_LO;
            r_cnt <= '0;
            r_level <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
      endcase
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: polarity-corrects, synchronises and debounces the three board inputs
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = 19,
  parameter logic [2:0] INVERT = 3'b000
) (
  input logic clock,
  input logic reset_sync,
  input_conditioner_if.slave bus
);
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_out;
  assign w_raw = {bus.prog_raw, bus.walk_raw, bus.sensor_raw} ^ INVERT;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    input_conditioner_debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W),
      .PULSE(g == WALK)
    ) u_ch (
      .clock(clock),
      .reset_sync(reset_sync),
      .i_raw(w_raw[g]),
      .o_out(w_out[g])
    );
  end
  assign bus.sensor_sync = w_out[SENSOR];
  assign bus.wr_sync = w_out[WALK];
  assign bus.prog_sync = w_out[PROG];
endmodule
